// File: rtl/kmean_stream_loader_if.sv
// kmean_stream_loader_if: stream input, config outputs and pixel-memory write port of the loader.
// The slave side is the loader itself; the master side is the stream source and the memory/engine.
interface kmean_stream_loader_if #(
    parameter int PIX_W = 24,
    parameter int AW    = 14
);
    logic [PIX_W-1:0] sin;
    logic             compute_done;
    logic [4:0]       cfg_k;
    logic [AW-1:0]    cfg_size;
    logic             cfg_err;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [PIX_W-1:0] mem_wdata;
    logic             start;
    logic             busy;
    logic             strb;
    modport master (
        output sin, compute_done,
        input  cfg_k, cfg_size, cfg_err, mem_we, mem_addr, mem_wdata, start, busy, strb
    );
    modport slave (
        input  sin, compute_done,
        output cfg_k, cfg_size, cfg_err, mem_we, mem_addr, mem_wdata, start, busy, strb
    );
endinterface

// File: rtl/kmean_stream_loader.sv
// kmean_stream_loader: config + pixel stream receiver feeding the k-means pixel memory.
// Define LOADER_CFG_CHECK_EN to flag bad config words on cfg_err and clamp bad sizes.
module kmean_stream_loader #(
    parameter int DATA_SIZE = 10000,
    parameter int PIX_W     = 24,
    parameter int AW        = $clog2(DATA_SIZE)
) (
    input logic                  clk,
    input logic                  reset,
    kmean_stream_loader_if.slave bus
);
    typedef enum logic [2:0] {SKIP, CFG, LOAD, RUN, DONE} state_t;
    state_t        state, nxt;
    logic [AW-1:0] cnt, size_d;
    logic [4:0]    k_d;
    logic          err_d, go;
`ifdef LOADER_CFG_CHECK_EN
    localparam logic [AW:0] DMAX = (AW+1)'(DATA_SIZE);
    logic bad_size;
    always_comb begin
        bad_size = bus.sin[AW-1:0] == '0 || {1'b0, bus.sin[AW-1:0]} > DMAX;
        size_d   = bad_size ? DMAX[AW-1:0] : bus.sin[AW-1:0];
        err_d    = bad_size || |bus.sin[PIX_W-1:AW+4];
    end
`else
    assign size_d = bus.sin[AW-1:0];
    assign err_d  = 1'b0;
`endif
    assign k_d = bus.sin[AW+3:AW] == 4'd0 ? 5'd16 : {1'b0, bus.sin[AW+3:AW]};
    always_comb begin
        nxt = state;
        case (state)
            SKIP:    nxt = CFG;
            CFG:     nxt = size_d == '0 ? RUN : LOAD;
            LOAD:    nxt = cnt == bus.cfg_size - AW'(1) ? RUN : LOAD;
            RUN:     nxt = bus.compute_done ? DONE : RUN;
            default: nxt = CFG;
        endcase
    end
    always_ff @(posedge clk) state <= reset ? SKIP : nxt;
    // go marks the first RUN cycle so start lands right after the last write
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt           <= '0;
            go            <= 1'b0;
            bus.cfg_k     <= 5'd16;
            bus.cfg_size  <= '0;
            bus.cfg_err   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.start     <= 1'b0;
            bus.busy      <= 1'b0;
            bus.strb      <= 1'b0;
        end else begin
            go         <= nxt == RUN && state != RUN;
            bus.start  <= go;
            bus.strb   <= state == RUN && bus.compute_done;
            bus.busy   <= nxt inside {LOAD, RUN, DONE};
            bus.mem_we <= state == LOAD;
            if (state == CFG) begin
                cnt          <= '0;
                bus.cfg_k    <= k_d;
                bus.cfg_size <= size_d;
                bus.cfg_err  <= err_d;
            end
            if (state == LOAD) begin
                cnt           <= cnt + AW'(1);
                bus.mem_addr  <= cnt;
                bus.mem_wdata <= bus.sin;
            end
        end
    end
endmodule

// File: tb/tb_kmean_stream_loader.sv
// tb_kmean_stream_loader: frame-level schedule model of the loader checked cycle by cycle.
// Frame cycle 0 is the CFG cycle; writes occupy cycles 2..size+1, start is at size+2.
module tb_kmean_stream_loader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    kmean_stream_loader_if #(.PIX_W(24), .AW(14)) bus ();
    kmean_stream_loader #(.DATA_SIZE(10000), .PIX_W(24)) dut (.clk(clk), .reset(reset), .bus(bus));
    int checks = 0;
    int failures = 0;
    logic [23:0] pix [0:10015];
    typedef struct {
        int n;
        int k;
        int rsv;
        int ws;
        int ek;
        int eerr;
        int dly;
        bit dil;
        bit idx;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, c, act, exp);
        end
    endtask

    task automatic chk_reset(input int c);
        chk("rst_cfg_k", c, 32'(bus.cfg_k), 16);
        chk("rst_cfg_size", c, 32'(bus.cfg_size), 0);
        chk("rst_cfg_err", c, 32'(bus.cfg_err), 0);
        chk("rst_mem_we", c, 32'(bus.mem_we), 0);
        chk("rst_mem_addr", c, 32'(bus.mem_addr), 0);
        chk("rst_mem_wdata", c, 32'(bus.mem_wdata), 0);
        chk("rst_start", c, 32'(bus.start), 0);
        chk("rst_busy", c, 32'(bus.busy), 0);
        chk("rst_strb", c, 32'(bus.strb), 0);
    endtask

    // Entered just before the negedge of the frame's CFG cycle; abort>0 resets during that cycle.
    task automatic frame(input vec_t v, input int abort);
        int d;
        logic [23:0] w;
        d = v.ws + 1 + v.dly;
        w = {6'(v.rsv), 4'(v.k), 14'(v.n)};
        for (int i = 0; i < v.ws; i++) pix[i] = v.idx ? 24'(i) : 24'($urandom);
        for (int c = 0; c <= d + 1; c++) begin
            @(negedge clk);
            chk("mem_we", c, 32'(bus.mem_we), 32'(c >= 2 && c <= v.ws + 1));
            if (c >= 2 && c <= v.ws + 1) begin
                chk("mem_addr", c, 32'(bus.mem_addr), c - 2);
                chk("mem_wdata", c, 32'(bus.mem_wdata), 32'(pix[c-2]));
            end
            chk("start", c, 32'(bus.start), 32'(c == v.ws + 2));
            chk("strb", c, 32'(bus.strb), 32'(c == d + 1));
            chk("busy", c, 32'(bus.busy), 32'(c >= 1));
            if (c >= 1) begin
                chk("cfg_k", c, 32'(bus.cfg_k), v.ek);
                chk("cfg_size", c, 32'(bus.cfg_size), v.ws);
                chk("cfg_err", c, 32'(bus.cfg_err), v.eerr);
            end
            bus.sin = c == 0 ? w : (c <= v.ws ? pix[c-1] : 24'($urandom));
            bus.compute_done = c == d || (v.dil && c <= v.ws);
            if (abort != 0 && c == abort) begin
                reset = 1'b1;
                @(negedge clk);
                chk_reset(c + 1);
                reset = 1'b0;
                bus.compute_done = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        vec_t r;
        tbl[0] = '{4, 0, 0, 4, 16, 0, 1, 0, 0};
        tbl[1] = '{1, 1, 0, 1, 1, 0, 0, 0, 0};
        tbl[2] = '{2, 15, 0, 2, 15, 0, 50, 0, 0};
        tbl[3] = '{7, 8, 0, 7, 8, 0, 3, 1, 0};
        tbl[4] = '{10000, 5, 0, 10000, 5, 0, 2, 0, 1};
`ifdef LOADER_CFG_CHECK_EN
        tbl[5] = '{0, 3, 32, 10000, 3, 1, 4, 0, 0};
        tbl[6] = '{3, 9, 5, 3, 9, 1, 1, 0, 0};
        tbl[7] = '{10005, 2, 0, 10000, 2, 1, 0, 0, 0};
`else
        tbl[5] = '{0, 3, 32, 0, 3, 0, 4, 1, 0};
        tbl[6] = '{3, 9, 5, 3, 9, 0, 1, 0, 0};
        tbl[7] = '{10005, 2, 0, 10005, 2, 0, 0, 0, 0};
`endif
        bus.sin = '0;
        bus.compute_done = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset(0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) frame(tbl[i], 0);
        frame('{5, 4, 0, 5, 4, 0, 0, 0, 0}, 3);
        frame('{3, 0, 0, 3, 16, 0, 2, 0, 0}, 0);
        for (int i = 0; i < 6; i++) begin
            r.n = int'($urandom_range(1, 20));
            r.k = int'($urandom_range(0, 15));
            r.rsv = 0;
            r.ws = r.n;
            r.ek = r.k == 0 ? 16 : r.k;
            r.eerr = 0;
            r.dly = int'($urandom_range(0, 8));
            r.dil = 1'($urandom_range(0, 1));
            r.idx = 1'b0;
            frame(r, 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/kmean_stream_loader.md
# kmean_stream_loader

Front-end receiver for the k-means core's 24-bit serial input `sin` stream. It consumes one configuration word, then `image_size` RGB pixels, one word per clock. It writes the pixels into the core's pixel memory, pulses `start` to the compute engine, and returns a one-cycle `strb` to the stream source when the engine reports completion.

## Interface
- `DATA_SIZE`, 10000: pixel memory depth and maximum image size.
- `PIX_W`, 24: width of a stream word and of a pixel.
- `AW`, `$clog2(DATA_SIZE)`: width of addresses and of the size field (14 at the default).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `sin`  in  PIX_W  stream word; the source changes it on the falling edge.
- `compute_done`  in  1  level or pulse from the compute engine; sampled only in RUN.
- `cfg_k`  out  5  cluster count, 1..16.
- `cfg_size`  out  AW  number of pixels in the frame.
- `cfg_err`  out  1  configuration fault flag; always 0 without the macro.
- `mem_we`  out  1  pixel memory write enable.
- `mem_addr`  out  AW  pixel memory write address.
- `mem_wdata`  out  PIX_W  pixel memory write data.
- `start`  out  1  one-cycle pulse to the compute engine.
- `busy`  out  1  high in every state except SKIP and CFG.
- `strb`  out  1  one-cycle completion pulse back to the source.

## Operation
- Config word layout: `sin[AW-1:0]` = image_size; `sin[AW+3:AW]` = K field; remaining upper bits are reserved (0).
- `cfg_k` = 16 when the K field is 0; otherwise `cfg_k` = the K field.
- FSM states: SKIP, CFG, LOAD, RUN, DONE.
- SKIP: the first cycle after reset. `sin` is ignored. Next state is CFG.
- CFG: capture the config word into `cfg_k` and `cfg_size`, and clear `cnt`.
  - If size ≠ 0, next state is LOAD.
  - If size = 0 (macro off), next state is RUN and `start` is issued with no writes.
- LOAD: each cycle, sample `sin` as pixel `cnt` and increment `cnt`. When `cnt == cfg_size-1` is sampled, next state is RUN.
- RUN: wait for `compute_done`. On the edge where it is sampled high, next state is DONE.
- DONE: `strb` is high for this one cycle. Next state is CFG, ready for the next frame with no SKIP cycle.
- `compute_done` outside RUN is ignored.
- Writes never exceed `cfg_size`. Words arriving after the last pixel and before DONE are ignored.

## Timing
- All outputs are registered. Reset values: `cfg_k`=16, `cfg_size`=0, `cfg_err`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `start`=0, `busy`=0, `strb`=0. State resets to SKIP and `cnt` to 0.
- Reset mid-operation: everything returns to the reset values on the next edge. A partial frame is abandoned and `mem_we` drops immediately.
- Write latency: pixel i sampled at edge e → `mem_we`=1, `mem_addr`=i, `mem_wdata`=pixel i during the cycle after e.
- Writes are back-to-back, one per cycle, for `cfg_size` cycles.
- `start` is high for exactly one cycle: the cycle immediately after the last `mem_we` cycle.
- `strb` rises one cycle after `compute_done` is sampled in RUN.
- Stream schedule after reset deasserts: edge 1 is don't-care (SKIP), edge 2 is the config word, edges 3..size+2 are pixels.
- Total input-to-`start` latency = size + 3 edges after reset release.

## Configuration
- `LOADER_CFG_CHECK_EN` defined: at CFG, `cfg_err`=1 if any of the following holds:
  - size = 0,
  - size > `DATA_SIZE`,
  - a reserved bit is nonzero.
- On size = 0 or size > `DATA_SIZE`, `cfg_size` is clamped to `DATA_SIZE` and the frame loads normally. A reserved-bit fault alone leaves the size unchanged.
- `cfg_err` holds until the next CFG or reset.
- Undefined: no checks are made and `cfg_err` is tied 0. Size 0 gives an immediate RUN with no writes. Size > `DATA_SIZE` is taken verbatim: addresses ≥ `DATA_SIZE` are written and the memory handles them (wrap or discard).

## Test plan
- Reset, then config {0, K=0, size=4}, then pixels A0,A1,A2,A3 → `cfg_k`=16; writes at addr 0..3 with data A0..A3 on consecutive cycles; `start` in the 5th cycle after the first write cycle.
- Full frame: size=10000, K=5, pixels = index → exactly 10000 writes, last at addr 9999; `start` once; extra trailing words are ignored.
- In RUN, hold `compute_done` low for 50 cycles, then pulse it once → `strb` is high for exactly one cycle, one edge later; the FSM is back in CFG and a second frame of size 2 loads correctly.
- Assert `reset` while the 3rd pixel is being sampled → `mem_we` is 0 on the next cycle; re-run with size 3 and verify addresses restart at 0.
- `compute_done` high during LOAD → no `strb` and no state change.
- With the macro defined, config size=0 with reserved bit 23 set → `cfg_err`=1, `cfg_size`=10000. With it undefined, size=0 → `start` follows with no writes and `cfg_err`=0.
